// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - data-memory port arbiter between pipeline and DMA with starvation-forced bursts
module dmem_port_arbiter #(
    parameter int ADDR_W     = 30,
    parameter int STARVE_MAX = 4,
    parameter int BURST_MAX  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pipe_en_i,
    input  logic [3:0]        pipe_we_i,
    input  logic [ADDR_W-1:0] pipe_addr_i,
    input  logic [31:0]       pipe_wdata_i,
    output logic              pipe_stall_o,
    output logic [31:0]       pipe_rdata_o,
    output logic              pipe_rvalid_o,
    input  logic              dma_req_i,
    input  logic [3:0]        dma_we_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [31:0]       dma_wdata_i,
    output logic              dma_gnt_o,
    output logic [31:0]       dma_rdata_o,
    output logic              dma_rvalid_o,
    output logic              mem_en_o,
    output logic [3:0]        mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    localparam int SW = $clog2(STARVE_MAX) + 1;
    localparam int BW = $clog2(BURST_MAX) + 1;

    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);
    localparam logic [SW-1:0] STARVE_SAT  = SW'(STARVE_MAX);
    localparam logic [BW-1:0] BURST_LAST  = BW'(BURST_MAX - 1);

    localparam logic       ST_PIPE_PRI  = 1'b0;
    localparam logic       ST_DMA_FORCE = 1'b1;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_PIPE = 2'd1;
    localparam logic [1:0] OWN_DMA  = 2'd2;

    logic          state;
    logic [SW-1:0] starve_cnt;
    logic [BW-1:0] burst_cnt;
    logic [1:0]    rd_owner;
    logic          pipe_gnt;
    logic          dma_gnt;

    // Grant decision and SRAM port mux; DMA only displaces an active pipeline access when forced.
    always_comb begin
        dma_gnt     = dma_req_i & ((state == ST_DMA_FORCE) | ~pipe_en_i);
        pipe_gnt    = pipe_en_i & ~dma_gnt;
        mem_en_o    = 1'b0;
        mem_we_o    = 4'h0;
        mem_addr_o  = '0;
        mem_wdata_o = 32'h0;
        if (dma_gnt) begin
            mem_en_o    = 1'b1;
            mem_we_o    = dma_we_i;
            mem_addr_o  = dma_addr_i;
            mem_wdata_o = dma_wdata_i;
        end else if (pipe_gnt) begin
            mem_en_o    = 1'b1;
            mem_we_o    = pipe_we_i;
            mem_addr_o  = pipe_addr_i;
            mem_wdata_o = pipe_wdata_i;
        end
    end

    assign dma_gnt_o     = dma_gnt;
    assign pipe_stall_o  = pipe_en_i & ~pipe_gnt;
    assign pipe_rdata_o  = mem_rdata_i;
    assign dma_rdata_o   = mem_rdata_i;
    assign pipe_rvalid_o = (rd_owner == OWN_PIPE);
    assign dma_rvalid_o  = (rd_owner == OWN_DMA);

    // Track which requester issued the read whose data the SRAM returns next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_owner <= OWN_NONE;
        end else if (dma_gnt && dma_we_i == 4'h0) begin
            rd_owner <= OWN_DMA;
        end else if (pipe_gnt && pipe_we_i == 4'h0) begin
            rd_owner <= OWN_PIPE;
        end else begin
            rd_owner <= OWN_NONE;
        end
    end

    // Starvation counting in priority mode and burst limiting in forced mode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_PIPE_PRI;
            starve_cnt <= '0;
            burst_cnt  <= '0;
        end else if (state == ST_PIPE_PRI) begin
            if (dma_req_i && !dma_gnt) begin
                if (starve_cnt == STARVE_LAST) begin
                    state      <= ST_DMA_FORCE;
                    starve_cnt <= '0;
                    burst_cnt  <= '0;
                end else if (starve_cnt != STARVE_SAT) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else begin
                starve_cnt <= '0;
            end
        end else begin
            if (!dma_req_i || burst_cnt == BURST_LAST) begin
                state      <= ST_PIPE_PRI;
                starve_cnt <= '0;
                burst_cnt  <= '0;
            end else begin
                burst_cnt <= burst_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - randomized model-checked bench for dmem_port_arbiter
module tb_dmem_port_arbiter;

    localparam int AW = 30;
    localparam int SM = 4;
    localparam int BM = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pipe_en_i, dma_req_i;
    logic [3:0]    pipe_we_i, dma_we_i;
    logic [AW-1:0] pipe_addr_i, dma_addr_i;
    logic [31:0]   pipe_wdata_i, dma_wdata_i, mem_rdata_i;
    logic          pipe_stall_o, pipe_rvalid_o, dma_gnt_o, dma_rvalid_o, mem_en_o;
    logic [31:0]   pipe_rdata_o, dma_rdata_o, mem_wdata_o;
    logic [3:0]    mem_we_o;
    logic [AW-1:0] mem_addr_o;

    int checks = 0;
    int failures = 0;

    // reference model: mode, counters and who owns the returning read
    bit m_forced;
    int m_starve;
    int m_burst;
    int m_owner; // 0 none, 1 pipe, 2 dma

    logic obs_stall, obs_dgnt, obs_prv, obs_drv;

    dmem_port_arbiter #(.ADDR_W(AW), .STARVE_MAX(SM), .BURST_MAX(BM)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_en_i(pipe_en_i), .pipe_we_i(pipe_we_i), .pipe_addr_i(pipe_addr_i),
        .pipe_wdata_i(pipe_wdata_i), .pipe_stall_o(pipe_stall_o),
        .pipe_rdata_o(pipe_rdata_o), .pipe_rvalid_o(pipe_rvalid_o),
        .dma_req_i(dma_req_i), .dma_we_i(dma_we_i), .dma_addr_i(dma_addr_i),
        .dma_wdata_i(dma_wdata_i), .dma_gnt_o(dma_gnt_o),
        .dma_rdata_o(dma_rdata_o), .dma_rvalid_o(dma_rvalid_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic pe, input logic [3:0] pwe, input logic [AW-1:0] pa,
                        input logic [31:0] pwd, input logic dr, input logic [3:0] dwe,
                        input logic [AW-1:0] da, input logic [31:0] dwd,
                        input logic [31:0] rd, input logic rn);
        bit e_pg, e_dg;
        @(negedge clk);
        pipe_en_i = pe; pipe_we_i = pwe; pipe_addr_i = pa; pipe_wdata_i = pwd;
        dma_req_i = dr; dma_we_i = dwe; dma_addr_i = da; dma_wdata_i = dwd;
        mem_rdata_i = rd; rst_n = rn;
        #1;
        // forced mode: a requesting DMA always wins; otherwise the pipeline does
        if (m_forced) begin
            e_dg = dr;
            e_pg = pe && !dr;
        end else begin
            e_pg = pe;
            e_dg = dr && !pe;
        end
        obs_stall = pipe_stall_o; obs_dgnt = dma_gnt_o;
        obs_prv = pipe_rvalid_o; obs_drv = dma_rvalid_o;
        if (rn) begin
            chk("dma_gnt", dma_gnt_o, e_dg);
            chk("pipe_stall", pipe_stall_o, pe && !e_pg);
            chk("mem_en", mem_en_o, e_pg || e_dg);
            chk("mem_we", mem_we_o, e_dg ? dwe : (e_pg ? pwe : 4'h0));
            chk("mem_addr", mem_addr_o, e_dg ? da : (e_pg ? pa : '0));
            chk("mem_wdata", mem_wdata_o, e_dg ? dwd : (e_pg ? pwd : 32'h0));
            chk("pipe_rvalid", pipe_rvalid_o, m_owner == 1);
            chk("dma_rvalid", dma_rvalid_o, m_owner == 2);
            if (m_owner == 1) chk("pipe_rdata", pipe_rdata_o, rd);
            if (m_owner == 2) chk("dma_rdata", dma_rdata_o, rd);
        end
        @(posedge clk);
        if (!rn) begin
            m_forced = 0; m_starve = 0; m_burst = 0; m_owner = 0;
        end else begin
            if (e_dg && dwe == 0) m_owner = 2;
            else if (e_pg && pwe == 0) m_owner = 1;
            else m_owner = 0;
            if (!m_forced) begin
                if (dr && !e_dg) begin
                    m_starve = (m_starve + 1 > SM) ? SM : m_starve + 1;
                    if (m_starve == SM) begin
                        m_forced = 1; m_burst = 0; m_starve = 0;
                    end
                end else begin
                    m_starve = 0;
                end
            end else begin
                if (e_dg) m_burst++;
                if (!dr || m_burst >= BM) begin
                    m_forced = 0; m_starve = 0; m_burst = 0;
                end
            end
        end
    endtask

    task automatic do_reset();
        step(0, 0, '0, 0, 0, 0, '0, 0, 0, 0);
        step(0, 0, '0, 0, 0, 0, '0, 0, 0, 1);
    endtask

    initial begin
        rst_n = 1'b0; pipe_en_i = 0; dma_req_i = 0; pipe_we_i = 0; dma_we_i = 0;
        pipe_addr_i = '0; dma_addr_i = '0; pipe_wdata_i = 0; dma_wdata_i = 0; mem_rdata_i = 0;
        m_forced = 0; m_starve = 0; m_burst = 0; m_owner = 0;

        // reset state
        do_reset();
        chk("rst_prv", obs_prv, 0);
        chk("rst_drv", obs_drv, 0);
        chk("rst_gnt", obs_dgnt, 0);
        chk("rst_stall", obs_stall, 0);

        // pipe read then rdata return
        step(1, 4'h0, 30'h10, 0, 0, 0, '0, 0, 32'h0, 1);
        step(0, 0, '0, 0, 0, 0, '0, 0, 32'hCAFE0001, 1);
        chk("t1_prv", obs_prv, 1);
        chk("t1_drv", obs_drv, 0);

        // DMA write in idle slot
        step(0, 0, '0, 0, 1, 4'hF, 30'h20, 32'h12345678, 0, 1);
        chk("t2_gnt", obs_dgnt, 1);
        step(0, 0, '0, 0, 0, 0, '0, 0, 0, 1);
        chk("t2_no_rv", {31'b0, obs_prv | obs_drv}, 0);

        // both continuous: forced windows at cycles 4-7 and 12-15
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1, 4'h3, 30'(i), 32'(i), 1, 4'h1, 30'(i + 100), 32'(i + 7), 0, 1);
            chk("t3_stall", obs_stall, (i % 8) >= 4);
            chk("t3_gnt", obs_dgnt, (i % 8) >= 4);
        end

        // forced window ends early when DMA stops requesting
        do_reset();
        for (int i = 0; i < 6; i++) step(1, 4'h1, '0, 0, 1, 4'h1, '0, 0, 0, 1);
        step(1, 4'h1, '0, 0, 0, 0, '0, 0, 0, 1);
        chk("t4_stall_exit", obs_stall, 0);
        step(1, 4'h1, '0, 0, 1, 4'h1, '0, 0, 0, 1);
        chk("t4_pipe_pri", obs_stall, 0);
        chk("t4_no_gnt", obs_dgnt, 0);

        // pipe read then DMA read back to back
        do_reset();
        step(1, 4'h0, 30'h5, 0, 0, 0, '0, 0, 0, 1);
        step(0, 0, '0, 0, 1, 4'h0, 30'h6, 0, 32'h11, 1);
        chk("t5_prv", obs_prv, 1);
        chk("t5_drv_n1", obs_drv, 0);
        step(0, 0, '0, 0, 0, 0, '0, 0, 32'h22, 1);
        chk("t5_drv", obs_drv, 1);
        chk("t5_prv_n2", obs_prv, 0);

        // reset during forced window with DMA read in flight
        for (int i = 0; i < 5; i++) step(1, 4'h1, '0, 0, 1, 4'h0, '0, 0, 0, 1);
        step(1, 4'h1, '0, 0, 1, 4'h0, '0, 0, 0, 0);
        step(1, 4'h0, 30'h9, 0, 0, 0, '0, 0, 32'h33, 1);
        chk("t6_drv", obs_drv, 0);
        chk("t6_stall", obs_stall, 0);
        chk("t6_gnt", obs_dgnt, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic pe, dr, rn;
            logic [3:0] pwe, dwe;
            pe  = ($urandom_range(0, 3) != 0);
            dr  = ($urandom_range(0, 3) != 0);
            pwe = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom);
            dwe = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom);
            rn  = ($urandom_range(0, 99) != 0);
            step(pe, pwe, AW'($urandom), $urandom, dr, dwe, AW'($urandom), $urandom, $urandom, rn);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
